dbg_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory command/response bus between the core load/store unit (requester 0) and the JTAG debug module (requester 1, the jtag_cmd_*/jtag_rsp_* channel).
- Sits between the core LSU, the jtag_top command/response ports and the system memory/bus fabric.
- Selects one command per handshake and records which requester owns each outstanding transaction.
- Routes responses back in order to the requester that issued them.

---
 rtl/dbg_mem_arbiter_pkg.sv | 24 ++
 rtl/dbg_mem_arbiter_if.sv | 32 +++
 rtl/dbg_mem_arbiter_arb_id_fifo.sv | 64 ++++++
 rtl/dbg_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_dbg_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_mem_arbiter_pkg.sv
// Shared definitions for the debug/LSU memory arbiter.
// Contents: requester ids, arbiter lock states, default widths and depth.
package dbg_mem_arbiter_pkg;

   localparam int DBG_ARB_ADDR_W = 32;
   localparam int DBG_ARB_DATA_W = 32;

   localparam int DBG_ARB_MASK_W     = DBG_ARB_DATA_W / 8;
   localparam int DBG_ARB_OUTS_DEPTH = 2;

   // Requester ids as stored in the outstanding-transaction FIFO.
   typedef enum logic {
      DBG_ARB_ID_LSU  = 1'b0,
      DBG_ARB_ID_JTAG = 1'b1
   } arb_id_e;

   // OPEN: a new grant may be chosen. LOCKED: a command is waiting on the
   // fabric and its grant must not move.
   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dbg_mem_arbiter_if.sv
// Memory command/response bus bundle.
// Signals: cmd_vld/cmd_rdy handshake with read, addr, wdata, wmask fields;
// rsp_vld/rsp_rdy handshake with err and rdata.
// master: issues commands and consumes responses.
// slave : accepts commands and produces responses.
interface dbg_mem_arbiter_if
   import dbg_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DBG_ARB_ADDR_W,
   parameter int DATA_W = DBG_ARB_DATA_W
) ();
   logic                cmd_vld;
   logic                cmd_rdy;
   logic                cmd_read;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W/8-1:0] cmd_wmask;
   logic                rsp_vld;
   logic                rsp_rdy;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_rdata;

   modport master (
      output cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_rdy,
      input  cmd_rdy, rsp_vld, rsp_err, rsp_rdata
   );

   modport slave (
      input  cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_rdy,
      output cmd_rdy, rsp_vld, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/dbg_mem_arbiter_arb_id_fifo.sv
// Small FIFO holding the owner id of each outstanding transaction.
// Ports: clk, rst_n (synchronous, active low), push_i/din_i, pop_i,
// full_o, empty_o, head_o (combinational view of the oldest entry).
// A push is allowed while full when a pop happens in the same cycle.
module arb_id_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointer wrap that also works for depths that are not a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // The slot freed by a same-cycle pop may be refilled immediately.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone says what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end
endmodule

// File: rtl/dbg_mem_arbiter.sv
// Shares one memory command/response bus between the core LSU (m0) and the
// JTAG debug module (m1). Commands are forwarded in zero cycles; the owner of
// every accepted command is queued so responses return in order to it.
// Ports: clk, rst_n (synchronous, active low), m0/m1 requester buses,
// s fabric bus, spurious_rsp_o (response with nothing outstanding),
// busy_o (transactions outstanding).
module dbg_mem_arbiter
   import dbg_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DBG_ARB_ADDR_W,
   parameter int DATA_W     = DBG_ARB_DATA_W,
   parameter int OUTS_DEPTH = DBG_ARB_OUTS_DEPTH,
   parameter bit JTAG_PRIO  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   dbg_mem_arbiter_if.slave  m0,
   dbg_mem_arbiter_if.slave  m1,
   dbg_mem_arbiter_if.master s,
   output logic              spurious_rsp_o,
   output logic              busy_o
);
   arb_state_e state_q, state_d;
   logic       lock_id_q, lock_id_d;
   logic       rr_q, rr_d;            // id favoured on the next contention
   logic       sel_rr, sel_free, sel;
   logic       gnt_vld, space, accept;
   logic       fifo_full, fifo_empty, head_id, pop;

   logic [ADDR_W-1:0]   addr_sel;
   logic [DATA_W-1:0]   wdata_sel;
   logic [DATA_W/8-1:0] wmask_sel;

   // ---------------- arbitration ----------------
   assign sel_rr   = (m0.cmd_vld && m1.cmd_vld) ? rr_q : m1.cmd_vld;
   assign sel_free = JTAG_PRIO ? m1.cmd_vld : sel_rr;
   assign sel      = (state_q == ARB_LOCKED) ? lock_id_q : sel_free;

   assign gnt_vld  = sel ? m1.cmd_vld : m0.cmd_vld;
   // A response popping this cycle frees a slot for this cycle's accept.
   assign space    = ~fifo_full | pop;

   assign addr_sel  = sel ? m1.cmd_addr  : m0.cmd_addr;
   assign wdata_sel = sel ? m1.cmd_wdata : m0.cmd_wdata;
   assign wmask_sel = sel ? m1.cmd_wmask : m0.cmd_wmask;

   assign s.cmd_vld   = rst_n & gnt_vld & space;
   assign s.cmd_read  = sel ? m1.cmd_read : m0.cmd_read;
   assign s.cmd_addr  = addr_sel;
   assign s.cmd_wdata = wdata_sel;
   assign s.cmd_wmask = wmask_sel;

   assign m0.cmd_rdy  = rst_n & ~sel & s.cmd_rdy & space;
   assign m1.cmd_rdy  = rst_n &  sel & s.cmd_rdy & space;

   assign accept      = s.cmd_vld & s.cmd_rdy;

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      rr_d      = rr_q;
      case (state_q)
         ARB_OPEN: begin
            if (s.cmd_vld && !s.cmd_rdy) begin
               state_d   = ARB_LOCKED;
               lock_id_d = sel;
            end
         end
         ARB_LOCKED: begin
            // A requester withdrawing its command also releases the lock so
            // the other side cannot be starved by a protocol violation.
            if (accept || !gnt_vld) begin
               state_d = ARB_OPEN;
            end
         end
         default: state_d = ARB_OPEN;
      endcase
      if (accept) begin
         rr_d = ~sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ARB_OPEN;
         lock_id_q <= DBG_ARB_ID_LSU;
         rr_q      <= DBG_ARB_ID_LSU;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         rr_q      <= rr_d;
      end
   end

   // ---------------- outstanding tracking ----------------
   arb_id_fifo #(
      .DEPTH (OUTS_DEPTH),
      .WIDTH (1)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .din_i   (sel),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_id)
   );

   // ---------------- response routing ----------------
   // With nothing outstanding the fabric response is sunk and flagged.
   assign s.rsp_rdy    = rst_n & (fifo_empty | (head_id ? m1.rsp_rdy : m0.rsp_rdy));
   assign pop          = s.rsp_vld & s.rsp_rdy & ~fifo_empty;

   assign m0.rsp_vld   = rst_n & s.rsp_vld & ~fifo_empty & ~head_id;
   assign m1.rsp_vld   = rst_n & s.rsp_vld & ~fifo_empty &  head_id;
   assign m0.rsp_err   = s.rsp_err;
   assign m1.rsp_err   = s.rsp_err;
   assign m0.rsp_rdata = s.rsp_rdata;
   assign m1.rsp_rdata = s.rsp_rdata;

   assign spurious_rsp_o = rst_n & s.rsp_vld & fifo_empty;
   assign busy_o         = rst_n & ~fifo_empty;
endmodule

// File: tb/tb_dbg_mem_arbiter.sv
module tb_dbg_mem_arbiter;
   localparam logic [31:0] ADDR0 = 32'h0000_1000;
   localparam logic [31:0] ADDR1 = 32'h0000_8000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_cmd_q [$];   // {read, owner id}, pushed by the stimulus
   logic       exp_rsp_q [$];   // owner ids in acceptance order

   logic spur, busy, spur2, busy2;

   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_if ();
   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_if ();
   dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ps_if ();

   dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(2), .JTAG_PRIO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
      .spurious_rsp_o(spur), .busy_o(busy)
   );

   dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(2), .JTAG_PRIO(1'b1)) dut_prio (
      .clk(clk), .rst_n(rst_n), .m0(p0_if), .m1(p1_if), .s(ps_if),
      .spurious_rsp_o(spur2), .busy_o(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted commands and delivered responses.
   always @(negedge clk) begin
      logic [1:0] e;
      logic       r;
      if (rst_n) begin
         if (s_if.cmd_vld && s_if.cmd_rdy) begin
            chk1("cmd_pending", exp_cmd_q.size() != 0, 1'b1);
            if (exp_cmd_q.size() != 0) begin
               e = exp_cmd_q.pop_front();
               chk1("cmd_owner", m1_if.cmd_rdy, e[0]);
               chk("cmd_addr", s_if.cmd_addr, e[0] ? ADDR1 : ADDR0);
               chk1("cmd_read", s_if.cmd_read, e[1]);
               exp_rsp_q.push_back(e[0]);
               $display("cmd accepted: owner=%0d addr=%h read=%0d", e[0], s_if.cmd_addr, s_if.cmd_read);
            end
         end
         if (m0_if.rsp_vld && m0_if.rsp_rdy) begin
            chk1("rsp0_pending", exp_rsp_q.size() != 0, 1'b1);
            if (exp_rsp_q.size() != 0) begin
               r = exp_rsp_q.pop_front();
               chk1("rsp0_owner", 1'b0, r);
               chk("rsp0_rdata", m0_if.rsp_rdata, s_if.rsp_rdata);
               chk1("rsp0_err", m0_if.rsp_err, s_if.rsp_err);
               $display("rsp to m0: rdata=%h err=%0d", m0_if.rsp_rdata, m0_if.rsp_err);
            end
         end
         if (m1_if.rsp_vld && m1_if.rsp_rdy) begin
            chk1("rsp1_pending", exp_rsp_q.size() != 0, 1'b1);
            if (exp_rsp_q.size() != 0) begin
               r = exp_rsp_q.pop_front();
               chk1("rsp1_owner", 1'b1, r);
               chk("rsp1_rdata", m1_if.rsp_rdata, s_if.rsp_rdata);
               chk1("rsp1_err", m1_if.rsp_err, s_if.rsp_err);
               $display("rsp to m1: rdata=%h err=%0d", m1_if.rsp_rdata, m1_if.rsp_err);
            end
         end
         chk1("rsp_onehot", m0_if.rsp_vld & m1_if.rsp_vld, 1'b0);
      end
   end

   initial begin
      rst_n = 1'b0;
      m0_if.cmd_vld = 1'b1; m0_if.cmd_read = 1'b1; m0_if.cmd_addr = ADDR0;
      m0_if.cmd_wdata = 32'h1111_1111; m0_if.cmd_wmask = 4'hF; m0_if.rsp_rdy = 1'b1;
      m1_if.cmd_vld = 1'b1; m1_if.cmd_read = 1'b1; m1_if.cmd_addr = ADDR1;
      m1_if.cmd_wdata = 32'h2222_2222; m1_if.cmd_wmask = 4'hF; m1_if.rsp_rdy = 1'b1;
      s_if.cmd_rdy = 1'b1; s_if.rsp_vld = 1'b0; s_if.rsp_err = 1'b0; s_if.rsp_rdata = '0;
      p0_if.cmd_vld = 1'b0; p0_if.cmd_read = 1'b1; p0_if.cmd_addr = ADDR0;
      p0_if.cmd_wdata = '0; p0_if.cmd_wmask = 4'hF; p0_if.rsp_rdy = 1'b1;
      p1_if.cmd_vld = 1'b0; p1_if.cmd_read = 1'b1; p1_if.cmd_addr = ADDR1;
      p1_if.cmd_wdata = '0; p1_if.cmd_wmask = 4'hF; p1_if.rsp_rdy = 1'b1;
      ps_if.cmd_rdy = 1'b0; ps_if.rsp_vld = 1'b0; ps_if.rsp_err = 1'b0; ps_if.rsp_rdata = '0;

      // Reset held for two cycles with both requesters valid.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("rst_m0_cmd_rdy", m0_if.cmd_rdy, 1'b0);
         chk1("rst_m1_cmd_rdy", m1_if.cmd_rdy, 1'b0);
         chk1("rst_s_cmd_vld", s_if.cmd_vld, 1'b0);
         chk1("rst_s_rsp_rdy", s_if.rsp_rdy, 1'b0);
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_spurious", spur, 1'b0);
         cyc();
      end

      // Round robin, responses returned immediately: m0,m1,m0,m1,m0.
      rst_n = 1'b1;
      s_if.rsp_vld = 1'b1; s_if.rsp_rdata = 32'h0000_A5A5;
      for (int i = 0; i < 5; i++) exp_cmd_q.push_back({1'b1, i[0]});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("rr_s_cmd_vld", s_if.cmd_vld, 1'b1);
         if (i == 0) chk1("rr_first_spurious", spur, 1'b1);
         cyc();
      end
      m0_if.cmd_vld = 1'b0; m1_if.cmd_vld = 1'b0;
      cyc();
      s_if.rsp_vld = 1'b0;
      @(negedge clk);
      chk1("rr_drained_busy", busy, 1'b0);
      cyc();

      // Lock: m0 waits on the fabric while m1 (now favoured) raises valid.
      m0_if.cmd_vld = 1'b1; s_if.cmd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) m1_if.cmd_vld = 1'b1;
         @(negedge clk);
         chk1("lock_s_cmd_vld", s_if.cmd_vld, 1'b1);
         chk("lock_s_cmd_addr", s_if.cmd_addr, ADDR0);
         chk1("lock_m1_cmd_rdy", m1_if.cmd_rdy, 1'b0);
         cyc();
      end
      exp_cmd_q.push_back(2'b10); s_if.cmd_rdy = 1'b1;
      @(negedge clk);
      chk1("lock_release_m0_rdy", m0_if.cmd_rdy, 1'b1);
      cyc();
      exp_cmd_q.push_back(2'b11);
      @(negedge clk);
      chk1("after_lock_m1_rdy", m1_if.cmd_rdy, 1'b1);
      cyc();

      // Two outstanding: a third command stalls until a response pops.
      m1_if.cmd_vld = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("full_s_cmd_vld", s_if.cmd_vld, 1'b0);
         chk1("full_m0_cmd_rdy", m0_if.cmd_rdy, 1'b0);
         chk1("full_busy", busy, 1'b1);
         cyc();
      end
      exp_cmd_q.push_back(2'b10);
      s_if.rsp_vld = 1'b1; s_if.rsp_rdata = 32'hDEAD_BEEF; s_if.rsp_err = 1'b0;
      @(negedge clk);
      chk1("full_rsp_m0_vld", m0_if.rsp_vld, 1'b1);
      chk("full_rsp_rdata", m0_if.rsp_rdata, 32'hDEAD_BEEF);
      chk1("full_same_cycle_accept", s_if.cmd_vld, 1'b1);
      cyc();
      m0_if.cmd_vld = 1'b0; s_if.rsp_rdata = 32'h1234_5678;
      @(negedge clk);
      chk1("drain_m1_rsp_vld", m1_if.rsp_vld, 1'b1);
      cyc();
      @(negedge clk);
      chk1("drain_m0_rsp_vld", m0_if.rsp_vld, 1'b1);
      cyc();
      s_if.rsp_vld = 1'b0;
      @(negedge clk);
      chk1("full_drained_busy", busy, 1'b0);
      cyc();

      // Routing by owner with response backpressure: m1 read, then m0 write.
      m1_if.cmd_vld = 1'b1; exp_cmd_q.push_back(2'b11);
      @(negedge clk); cyc();
      m1_if.cmd_vld = 1'b0; m0_if.cmd_vld = 1'b1; m0_if.cmd_read = 1'b0;
      exp_cmd_q.push_back(2'b00);
      @(negedge clk); cyc();
      m0_if.cmd_vld = 1'b0; m0_if.cmd_read = 1'b1;
      s_if.rsp_vld = 1'b1; s_if.rsp_err = 1'b1; s_if.rsp_rdata = 32'h0BAD_0BAD;
      m1_if.rsp_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("bp_m1_rsp_vld", m1_if.rsp_vld, 1'b1);
         chk1("bp_m0_rsp_vld", m0_if.rsp_vld, 1'b0);
         chk1("bp_s_rsp_rdy", s_if.rsp_rdy, 1'b0);
         chk1("bp_m1_rsp_err", m1_if.rsp_err, 1'b1);
         cyc();
      end
      m1_if.rsp_rdy = 1'b1;
      @(negedge clk);
      chk1("route_s_rsp_rdy", s_if.rsp_rdy, 1'b1);
      chk1("route_m1_rsp_vld", m1_if.rsp_vld, 1'b1);
      cyc();
      s_if.rsp_err = 1'b0; s_if.rsp_rdata = 32'h600D_600D;
      @(negedge clk);
      chk1("route_m0_rsp_vld", m0_if.rsp_vld, 1'b1);
      chk1("route_m1_rsp_idle", m1_if.rsp_vld, 1'b0);
      chk1("route_m0_rsp_err", m0_if.rsp_err, 1'b0);
      cyc();
      s_if.rsp_vld = 1'b0;
      @(negedge clk);
      chk1("route_drained_busy", busy, 1'b0);
      cyc();

      // Spurious response with nothing outstanding.
      s_if.rsp_vld = 1'b1; s_if.rsp_rdata = 32'hFFFF_0000;
      @(negedge clk);
      chk1("spur_s_rsp_rdy", s_if.rsp_rdy, 1'b1);
      chk1("spur_pulse", spur, 1'b1);
      chk1("spur_m0_rsp_vld", m0_if.rsp_vld, 1'b0);
      chk1("spur_m1_rsp_vld", m1_if.rsp_vld, 1'b0);
      cyc();
      s_if.rsp_vld = 1'b0;
      @(negedge clk);
      chk1("spur_pulse_end", spur, 1'b0);
      cyc();

      // Reset with a transaction outstanding: its response becomes spurious.
      m0_if.cmd_vld = 1'b1; exp_cmd_q.push_back(2'b10);
      @(negedge clk); cyc();
      m0_if.cmd_vld = 1'b0; rst_n = 1'b0; exp_rsp_q.delete();
      @(negedge clk);
      chk1("midrst_busy", busy, 1'b0);
      cyc();
      rst_n = 1'b1; s_if.rsp_vld = 1'b1;
      @(negedge clk);
      chk1("midrst_spurious", spur, 1'b1);
      chk1("midrst_m0_rsp_vld", m0_if.rsp_vld, 1'b0);
      chk1("midrst_busy_after", busy, 1'b0);
      cyc();
      s_if.rsp_vld = 1'b0;

      // Fixed JTAG priority instance: m1 wins every cycle.
      p0_if.cmd_vld = 1'b1; p1_if.cmd_vld = 1'b1;
      ps_if.cmd_rdy = 1'b1; ps_if.rsp_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("prio_m1_cmd_rdy", p1_if.cmd_rdy, 1'b1);
         chk1("prio_m0_cmd_rdy", p0_if.cmd_rdy, 1'b0);
         chk("prio_s_cmd_addr", ps_if.cmd_addr, ADDR1);
         if (i == 0) chk1("prio_first_spurious", spur2, 1'b1);
         else chk1("prio_busy", busy2, 1'b1);
         $display("prio cycle %0d: m1_rdy=%0d m0_rdy=%0d addr=%h", i, p1_if.cmd_rdy, p0_if.cmd_rdy, ps_if.cmd_addr);
         cyc();
      end
      p0_if.cmd_vld = 1'b0; p1_if.cmd_vld = 1'b0; ps_if.rsp_vld = 1'b0;
      cyc();

      chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
      chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
